// File: rtl/frog_game_ctrl.sv
// Game sequencer for the frog/lane VGA game: tracks play/death/goal phases,
// lives, score and level, and drives the frog hold and lane freeze lines.
module frog_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int GOAL_FRAMES  = 90,
  parameter int GOAL_Y       = 24,
  parameter int SCORE_W      = 8,
  parameter int LEVEL_MAX    = 7
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_animate,
  input  logic               i_start,
  input  logic               i_hit,
  input  logic [11:0]        i_frog_y1,
  output logic [2:0]         o_state,
  output logic               o_dead,
  output logic               o_freeze,
  output logic [1:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [2:0]         o_level,
  output logic               o_flash
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    DYING   = 3'd2,
    RESPAWN = 3'd3,
    GOAL    = 3'd4,
    OVER    = 3'd5
  } state_t;

  localparam logic [7:0]         DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0]         GOAL_LAST  = 8'(GOAL_FRAMES - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
  localparam logic [2:0]         LEVEL_TOP  = 3'(LEVEL_MAX);
  localparam logic [11:0]        GOAL_LINE  = 12'(GOAL_Y);
  localparam logic [SCORE_W-1:0] SCORE_FULL = {SCORE_W{1'b1}};

  state_t             state, state_nxt;
  logic [7:0]         frame_cnt, frame_nxt;
  logic               start_q;
  logic               start_rise;
  logic               goal_hit;
  logic [1:0]         lives_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [2:0]         level_nxt;
  logic               dead_nxt, freeze_nxt, flash_nxt;

  assign start_rise = i_start & ~start_q;
  assign goal_hit   = i_animate && (i_frog_y1 <= GOAL_LINE);
  assign o_state    = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      start_q   <= 1'b1;
      o_dead    <= 1'b1;
      o_freeze  <= 1'b1;
      o_lives   <= 2'd0;
      o_score   <= '0;
      o_level   <= 3'd0;
      o_flash   <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_nxt;
      start_q   <= i_start;
      o_dead    <= dead_nxt;
      o_freeze  <= freeze_nxt;
      o_lives   <= lives_nxt;
      o_score   <= score_nxt;
      o_level   <= level_nxt;
      o_flash   <= flash_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    lives_nxt = o_lives;
    score_nxt = o_score;
    level_nxt = o_level;

    case (state)
      IDLE, OVER: begin
        // The counter keeps running in OVER so the display keeps blinking.
        if (state == OVER && i_animate) frame_nxt = frame_cnt + 8'd1;
        if (start_rise) begin
          state_nxt = PLAY;
          lives_nxt = LIVES_INIT;
          score_nxt = '0;
          level_nxt = 3'd0;
        end
      end
      PLAY: begin
        if (i_hit) begin
          state_nxt = DYING;
          lives_nxt = o_lives - 2'd1;
          frame_nxt = 8'd0;
        end else if (goal_hit) begin
          state_nxt = GOAL;
          frame_nxt = 8'd0;
          if (o_score != SCORE_FULL) score_nxt = o_score + 1'b1;
          if (o_level < LEVEL_TOP) level_nxt = o_level + 3'd1;
        end
      end
      DYING: begin
        if (i_animate) begin
          frame_nxt = frame_cnt + 8'd1;
          if (frame_cnt == DEATH_LAST) state_nxt = (o_lives == 2'd0) ? OVER : RESPAWN;
        end
      end
      GOAL: begin
        if (i_animate) begin
          frame_nxt = frame_cnt + 8'd1;
          if (frame_cnt == GOAL_LAST) state_nxt = RESPAWN;
        end
      end
      RESPAWN: begin
        if (i_animate) state_nxt = PLAY;
      end
      default: state_nxt = IDLE;
    endcase

    dead_nxt   = (state_nxt != PLAY);
    freeze_nxt = (state_nxt == IDLE) || (state_nxt == GOAL) || (state_nxt == OVER);
    flash_nxt  = ((state_nxt == DYING) || (state_nxt == GOAL) || (state_nxt == OVER))
                 && frame_nxt[3];
  end

endmodule
